seven_segment_capture: RTL

// - Receive end of the two-digit multiplexed seven-segment display interface.
// - Samples segments/digit as driven by the display driver, decodes each pattern back to BCD
//   and rebuilds the ten/unit pair.
// - Publishes a pair only after it has been stable for STABLE_FRAMES frames.
// - Used as an on-chip display monitor and as the self-check for the frequency counter's

---
 rtl/seven_segment_capture_if.sv | 27 ++
 rtl/seven_segment_capture.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/seven_segment_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_capture_if
// Brief    : Multiplexed two-digit seven-segment bus plus the monitor's results.
// Revision : 1.0 - initial release
// ============================================================================
interface seven_segment_capture_if;
    logic [6:0] segments;
    logic       digit;
    logic [3:0] ten_count;
    logic [3:0] unit_count;
    logic       valid;
    logic       update;
    logic       pattern_err;
    logic       seq_err;

    modport master (
        output segments, digit,
        input  ten_count, unit_count, valid, update, pattern_err, seq_err
    );

    modport slave (
        input  segments, digit,
        output ten_count, unit_count, valid, update, pattern_err, seq_err
    );
endinterface
`default_nettype wire

// File: rtl/seven_segment_capture.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_capture
// Brief    : Decodes a multiplexed seven-segment display back to a BCD pair and
//            publishes it once it has been stable for STABLE_FRAMES frames.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_capture #(
    parameter int STABLE_FRAMES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    seven_segment_capture_if.slave   bus
);
    localparam logic [3:0] c_STABLE = 4'(STABLE_FRAMES);

    typedef enum logic [1:0] {
        ST_SYNC     = 2'd0,
        ST_GOT_UNIT = 2'd1,
        ST_GOT_TEN  = 2'd2
    } state_t;

    state_t     r_state;
    logic [6:0] r_seg;
    logic       r_dig;
    logic [3:0] r_unit_lat;
    logic [7:0] r_cand;
    logic [3:0] r_match;
    logic [3:0] r_ten;
    logic [3:0] r_unit;
    logic       r_valid;
    logic       r_update;
    logic       r_perr;
    logic       r_serr;

    logic [3:0] w_val;
    logic       w_legal;
    logic       w_seq_bad;
    logic [7:0] w_frame;
    logic       w_publish;

    always_comb begin
        w_legal = 1'b1;
        w_val   = 4'hF;
        case (r_seg)
            7'b0111111: w_val = 4'd0;
            7'b0000110: w_val = 4'd1;
            7'b1011011: w_val = 4'd2;
            7'b1001111: w_val = 4'd3;
            7'b1100110: w_val = 4'd4;
            7'b1101101: w_val = 4'd5;
            7'b1111100: w_val = 4'd6;
            7'b0000111: w_val = 4'd7;
            7'b1111111: w_val = 4'd8;
            7'b1100111: w_val = 4'd9;
            7'b0000000: w_val = 4'hF;
            default:    w_legal = 1'b0;
        endcase
    end

    assign w_seq_bad = ((r_state == ST_GOT_UNIT) && !r_dig) ||
                       ((r_state == ST_GOT_TEN)  &&  r_dig);
    assign w_frame   = {w_val, r_unit_lat};
    // Publish only a fully qualified candidate that differs from what is shown.
    assign w_publish = (r_match == c_STABLE) && (!r_valid || (r_cand != {r_ten, r_unit}));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_SYNC;
            r_seg      <= 7'd0;
            r_dig      <= 1'b0;
            r_unit_lat <= 4'd0;
            r_cand     <= 8'd0;
            r_match    <= 4'd0;
            r_ten      <= 4'd0;
            r_unit     <= 4'd0;
            r_valid    <= 1'b0;
            r_update   <= 1'b0;
            r_perr     <= 1'b0;
            r_serr     <= 1'b0;
        end else begin
            r_seg    <= bus.segments;
            r_dig    <= bus.digit;
            r_update <= 1'b0;
            r_perr   <= 1'b0;
            r_serr   <= 1'b0;

            if (w_publish) begin
                r_ten    <= r_cand[7:4];
                r_unit   <= r_cand[3:0];
                r_valid  <= 1'b1;
                r_update <= 1'b1;
            end

            if (!w_legal) begin
                r_perr  <= 1'b1;
                r_serr  <= w_seq_bad;
                r_match <= 4'd0;
                r_state <= ST_SYNC;
            end else begin
                case (r_state)
                    ST_SYNC: begin
                        if (!r_dig) begin
                            r_unit_lat <= w_val;
                            r_state    <= ST_GOT_UNIT;
                        end
                    end
                    ST_GOT_UNIT: begin
                        if (r_dig) begin
                            if (w_frame == r_cand) begin
                                r_match <= (r_match >= c_STABLE) ? c_STABLE : r_match + 4'd1;
                            end else begin
                                r_cand  <= w_frame;
                                r_match <= 4'd1;
                            end
                            r_state <= ST_GOT_TEN;
                        end else begin
                            // A repeated units sample replaces the pending unit.
                            r_serr     <= 1'b1;
                            r_unit_lat <= w_val;
                        end
                    end
                    ST_GOT_TEN: begin
                        if (!r_dig) begin
                            r_unit_lat <= w_val;
                            r_state    <= ST_GOT_UNIT;
                        end else begin
                            r_serr  <= 1'b1;
                            r_state <= ST_SYNC;
                        end
                    end
                    default: r_state <= ST_SYNC;
                endcase
            end
        end
    end

    assign bus.ten_count   = r_ten;
    assign bus.unit_count  = r_unit;
    assign bus.valid       = r_valid;
    assign bus.update      = r_update;
    assign bus.pattern_err = r_perr;
    assign bus.seq_err     = r_serr;
endmodule
`default_nettype wire
